// File: rtl/csr_access_ctrl_if.sv
// Bundles the pipeline request/response signals and the CSR file port of csr_access_ctrl.
// master = requesters plus CSR file (environment side), slave = the controller.
interface csr_access_ctrl_if #(
    parameter int XLEN = 64
);
    logic            inst_req;
    logic [11:0]     inst_addr;
    logic [2:0]      inst_op;
    logic [XLEN-1:0] inst_src;
    logic            inst_src_zero;
    logic            inst_done;
    logic            inst_illegal;
    logic [XLEN-1:0] inst_rdata;

    logic            trap_req;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic            trap_done;
    logic [XLEN-1:0] trap_vec;

    logic            csr_ren;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;

    logic            busy;

    modport master (
        output inst_req, inst_addr, inst_op, inst_src, inst_src_zero,
        input  inst_done, inst_illegal, inst_rdata,
        output trap_req, trap_epc, trap_cause, trap_tval,
        input  trap_done, trap_vec,
        input  csr_ren, csr_raddr, csr_we, csr_waddr, csr_wdata,
        output csr_rdata,
        input  busy
    );

    modport slave (
        input  inst_req, inst_addr, inst_op, inst_src, inst_src_zero,
        output inst_done, inst_illegal, inst_rdata,
        input  trap_req, trap_epc, trap_cause, trap_tval,
        output trap_done, trap_vec,
        output csr_ren, csr_raddr, csr_we, csr_waddr, csr_wdata,
        input  csr_rdata,
        output busy
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences CSR instruction read-modify-writes and trap-entry updates over a single
// synchronous-read CSR port; traps win arbitration in IDLE, nothing is preempted.
module csr_access_ctrl #(
    parameter int          XLEN        = 64,
    parameter logic [11:0] ADDR_MTVEC  = 12'h305,
    parameter logic [11:0] ADDR_MEPC   = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE = 12'h342,
    parameter logic [11:0] ADDR_MTVAL  = 12'h343
) (
    input logic          clk,
    input logic          rstn,
    csr_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, I_RD, I_WB, T_EPC, T_CAUSE, T_TVAL, T_VRD, T_VWB
    } state_e;

    state_e          state_q, state_d;
    logic [11:0]     addr_q, addr_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            src_zero_q, src_zero_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            ren_q, ren_d;
    logic [11:0]     raddr_q, raddr_d;
    logic            we_q, we_d;
    logic [11:0]     waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            inst_done_q, inst_done_d;
    logic            illegal_q, illegal_d;
    logic            trap_done_q, trap_done_d;

    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] trap_vec_c;

    // csr_rdata is only valid in the write-back cycles, so the data-dependent results are combinational
    always_comb begin
        new_val = src_q;
        case (op_q)
            3'b010, 3'b101: new_val = bus.csr_rdata | src_q;
            3'b011, 3'b110: new_val = bus.csr_rdata & ~src_q;
            default:        new_val = src_q;
        endcase
        vec_base   = {bus.csr_rdata[XLEN-1:2], 2'b00};
        trap_vec_c = vec_base;
        if (bus.csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1])
            trap_vec_c = vec_base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        src_d       = src_q;
        src_zero_d  = src_zero_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        ren_d       = 1'b0;
        raddr_d     = '0;
        we_d        = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        inst_done_d = 1'b0;
        illegal_d   = 1'b0;
        trap_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The requester is still high during an illegal-op done pulse; don't re-accept it
                if (!illegal_q) begin
                    if (bus.trap_req) begin
                        cause_d = bus.trap_cause;
                        tval_d  = bus.trap_tval;
                        state_d = T_EPC;
                        we_d    = 1'b1;
                        waddr_d = ADDR_MEPC;
                        wdata_d = bus.trap_epc & ~XLEN'(3);
                    end else if (bus.inst_req) begin
                        addr_d     = bus.inst_addr;
                        op_d       = bus.inst_op;
                        src_d      = bus.inst_src;
                        src_zero_d = bus.inst_src_zero;
                        if (bus.inst_op == 3'b000 || bus.inst_op == 3'b111) begin
                            inst_done_d = 1'b1;
                            illegal_d   = 1'b1;
                        end else begin
                            state_d = I_RD;
                            ren_d   = 1'b1;
                            raddr_d = bus.inst_addr;
                        end
                    end
                end
            end
            I_RD: begin
                state_d     = I_WB;
                inst_done_d = 1'b1;
                we_d        = !(src_zero_q && op_q != 3'b001 && op_q != 3'b100);
                waddr_d     = addr_q;
            end
            T_EPC: begin
                state_d = T_CAUSE;
                we_d    = 1'b1;
                waddr_d = ADDR_MCAUSE;
                wdata_d = cause_q;
            end
            T_CAUSE: begin
                state_d = T_TVAL;
                we_d    = 1'b1;
                waddr_d = ADDR_MTVAL;
                wdata_d = tval_q;
            end
            T_TVAL: begin
                state_d = T_VRD;
                ren_d   = 1'b1;
                raddr_d = ADDR_MTVEC;
            end
            T_VRD: begin
                state_d     = T_VWB;
                trap_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            src_q       <= '0;
            src_zero_q  <= 1'b0;
            cause_q     <= '0;
            tval_q      <= '0;
            ren_q       <= 1'b0;
            raddr_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            inst_done_q <= 1'b0;
            illegal_q   <= 1'b0;
            trap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            src_q       <= src_d;
            src_zero_q  <= src_zero_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            inst_done_q <= inst_done_d;
            illegal_q   <= illegal_d;
            trap_done_q <= trap_done_d;
        end
    end

    assign bus.inst_done    = inst_done_q;
    assign bus.inst_illegal = illegal_q;
    assign bus.inst_rdata   = (state_q == I_WB) ? bus.csr_rdata : '0;
    assign bus.trap_done    = trap_done_q;
    assign bus.trap_vec     = (state_q == T_VWB) ? trap_vec_c : '0;
    assign bus.csr_ren      = ren_q;
    assign bus.csr_raddr    = raddr_q;
    assign bus.csr_we       = we_q;
    assign bus.csr_waddr    = waddr_q;
    assign bus.csr_wdata    = (state_q == I_WB && we_q) ? new_val : wdata_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural synchronous-read CSR file.
module tb_csr_access_ctrl;

    logic clk;
    logic rstn;

    csr_access_ctrl_if #(.XLEN(64)) bus ();

    csr_access_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];
    logic [63:0] rdata_r;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [63:0] bd_data;
    int          wr_count;
    int          overlap_count;
    int          errors;
    int          checks;

    initial begin
        rdata_r       = '0;
        wr_count      = 0;
        overlap_count = 0;
    end

    // CSR file model: one-cycle read latency, writes land on the clock edge
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus.csr_ren) rdata_r <= mem[bus.csr_raddr];
        if (bus.csr_we) begin
            mem[bus.csr_waddr] <= bus.csr_wdata;
            wr_count <= wr_count + 1;
        end
        if (bus.csr_ren && bus.csr_we) overlap_count <= overlap_count + 1;
    end

    assign bus.csr_rdata = rdata_r;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [11:0] a, input logic [2:0] op,
                                 input logic [63:0] src, input logic zero);
        bus.inst_addr     = a;
        bus.inst_op       = op;
        bus.inst_src      = src;
        bus.inst_src_zero = zero;
        bus.inst_req      = 1'b1;
    endtask

    task automatic startTrap(input logic [63:0] epc, input logic [63:0] cause, input logic [63:0] tval);
        bus.trap_epc   = epc;
        bus.trap_cause = cause;
        bus.trap_tval  = tval;
        bus.trap_req   = 1'b1;
    endtask

    // Walks I_RD and I_WB starting from the cycle after the accept edge
    task automatic instSteps(input string tag, input logic [11:0] a, input logic [63:0] exp_rdata,
                             input logic exp_we, input logic [63:0] exp_wdata);
        @(negedge clk);
        checkOutput({tag, ".ren"}, 64'(bus.csr_ren), 64'd1);
        checkOutput({tag, ".raddr"}, 64'(bus.csr_raddr), 64'(a));
        checkOutput({tag, ".we_rd"}, 64'(bus.csr_we), 64'd0);
        checkOutput({tag, ".busy"}, 64'(bus.busy), 64'd1);
        bus.inst_src  = ~bus.inst_src;
        bus.inst_addr = 12'hFFF;
        @(negedge clk);
        checkOutput({tag, ".done"}, 64'(bus.inst_done), 64'd1);
        checkOutput({tag, ".illegal"}, 64'(bus.inst_illegal), 64'd0);
        checkOutput({tag, ".rdata"}, bus.inst_rdata, exp_rdata);
        checkOutput({tag, ".we"}, 64'(bus.csr_we), 64'(exp_we));
        checkOutput({tag, ".ren_wb"}, 64'(bus.csr_ren), 64'd0);
        if (exp_we) begin
            checkOutput({tag, ".waddr"}, 64'(bus.csr_waddr), 64'(a));
            checkOutput({tag, ".wdata"}, bus.csr_wdata, exp_wdata);
        end
        bus.inst_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".done_clr"}, 64'(bus.inst_done), 64'd0);
        checkOutput({tag, ".idle"}, 64'(bus.busy), 64'd0);
    endtask

    // Walks the five trap cycles starting from the cycle after the accept edge
    task automatic trapSteps(input string tag, input logic [63:0] exp_epc, input logic [63:0] cause,
                             input logic [63:0] tval, input logic [63:0] exp_vec);
        @(negedge clk);
        checkOutput({tag, ".epc_we"}, 64'(bus.csr_we), 64'd1);
        checkOutput({tag, ".epc_addr"}, 64'(bus.csr_waddr), 64'h341);
        checkOutput({tag, ".epc_data"}, bus.csr_wdata, exp_epc);
        bus.trap_epc = '0;
        @(negedge clk);
        checkOutput({tag, ".cause_addr"}, 64'(bus.csr_waddr), 64'h342);
        checkOutput({tag, ".cause_data"}, bus.csr_wdata, cause);
        @(negedge clk);
        checkOutput({tag, ".tval_addr"}, 64'(bus.csr_waddr), 64'h343);
        checkOutput({tag, ".tval_data"}, bus.csr_wdata, tval);
        @(negedge clk);
        checkOutput({tag, ".vrd_ren"}, 64'(bus.csr_ren), 64'd1);
        checkOutput({tag, ".vrd_we"}, 64'(bus.csr_we), 64'd0);
        checkOutput({tag, ".vrd_addr"}, 64'(bus.csr_raddr), 64'h305);
        checkOutput({tag, ".done_early"}, 64'(bus.trap_done), 64'd0);
        @(negedge clk);
        checkOutput({tag, ".done"}, 64'(bus.trap_done), 64'd1);
        checkOutput({tag, ".vec"}, bus.trap_vec, exp_vec);
        checkOutput({tag, ".inst_done"}, 64'(bus.inst_done), 64'd0);
        bus.trap_req = 1'b0;
    endtask

    int wr_snap;

    initial begin
        errors            = 0;
        checks            = 0;
        rstn              = 1'b0;
        bd_we             = 1'b0;
        bd_addr           = '0;
        bd_data           = '0;
        bus.inst_req      = 1'b0;
        bus.inst_addr     = '0;
        bus.inst_op       = '0;
        bus.inst_src      = '0;
        bus.inst_src_zero = 1'b0;
        bus.trap_req      = 1'b0;
        bus.trap_epc      = '0;
        bus.trap_cause    = '0;
        bus.trap_tval     = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 64'(bus.busy), 64'd0);
        checkOutput("reset.ren", 64'(bus.csr_ren), 64'd0);
        checkOutput("reset.we", 64'(bus.csr_we), 64'd0);
        checkOutput("reset.done", 64'(bus.inst_done), 64'd0);
        checkOutput("reset.trap_done", 64'(bus.trap_done), 64'd0);
        rstn = 1'b1;

        $display("[TB] csrrs / csrrc / csrrci / csrrwi");
        preload(12'h300, 64'h8);
        applyStimulus(12'h300, 3'b010, 64'h3, 1'b0);
        instSteps("csrrs", 12'h300, 64'h8, 1'b1, 64'hB);

        preload(12'h340, 64'hFF);
        wr_snap = wr_count;
        applyStimulus(12'h340, 3'b011, 64'h0, 1'b1);
        instSteps("csrrc_zero", 12'h340, 64'hFF, 1'b0, 64'h0);
        checkOutput("csrrc_zero.no_write", 64'(wr_count), 64'(wr_snap));

        applyStimulus(12'h340, 3'b110, 64'h0F, 1'b0);
        instSteps("csrrci", 12'h340, 64'hFF, 1'b1, 64'hF0);

        applyStimulus(12'h340, 3'b100, 64'h15, 1'b0);
        instSteps("csrrwi", 12'h340, 64'hF0, 1'b1, 64'h15);

        $display("[TB] trap entry, exception then vectored interrupt");
        preload(12'h305, 64'h80001001);
        startTrap(64'h80000104, 64'h2, 64'hDEAD);
        trapSteps("trap_exc", 64'h80000104, 64'h2, 64'hDEAD, 64'h80001000);
        @(negedge clk);
        checkOutput("trap_exc.idle", 64'(bus.busy), 64'd0);

        startTrap(64'h1003, 64'h8000000000000007, 64'h0);
        trapSteps("trap_irq", 64'h1000, 64'h8000000000000007, 64'h0, 64'h8000101C);
        @(negedge clk);
        checkOutput("trap_irq.idle", 64'(bus.busy), 64'd0);

        $display("[TB] simultaneous requests");
        applyStimulus(12'h340, 3'b001, 64'h77, 1'b0);
        startTrap(64'h2000, 64'h5, 64'h1234);
        trapSteps("simul_trap", 64'h2000, 64'h5, 64'h1234, 64'h80001000);
        @(negedge clk);
        checkOutput("simul.gap_busy", 64'(bus.busy), 64'd0);
        checkOutput("simul.gap_ren", 64'(bus.csr_ren), 64'd0);
        instSteps("simul_inst", 12'h340, 64'h15, 1'b1, 64'h77);

        $display("[TB] illegal op");
        wr_snap = wr_count;
        applyStimulus(12'h340, 3'b111, 64'h5, 1'b0);
        @(negedge clk);
        checkOutput("illegal.done", 64'(bus.inst_done), 64'd1);
        checkOutput("illegal.flag", 64'(bus.inst_illegal), 64'd1);
        checkOutput("illegal.rdata", bus.inst_rdata, 64'h0);
        checkOutput("illegal.ren", 64'(bus.csr_ren), 64'd0);
        checkOutput("illegal.we", 64'(bus.csr_we), 64'd0);
        bus.inst_req = 1'b0;
        @(negedge clk);
        checkOutput("illegal.done_clr", 64'(bus.inst_done), 64'd0);
        checkOutput("illegal.flag_clr", 64'(bus.inst_illegal), 64'd0);
        checkOutput("illegal.busy", 64'(bus.busy), 64'd0);
        checkOutput("illegal.no_write", 64'(wr_count), 64'(wr_snap));

        $display("[TB] reset during T_CAUSE");
        startTrap(64'h3000, 64'h9, 64'hBEEF);
        @(negedge clk);
        checkOutput("rst.epc_addr", 64'(bus.csr_waddr), 64'h341);
        @(negedge clk);
        checkOutput("rst.cause_addr", 64'(bus.csr_waddr), 64'h342);
        wr_snap = wr_count;
        rstn = 1'b0;
        #1;
        checkOutput("rst.we", 64'(bus.csr_we), 64'd0);
        checkOutput("rst.waddr", 64'(bus.csr_waddr), 64'd0);
        checkOutput("rst.wdata", bus.csr_wdata, 64'd0);
        checkOutput("rst.busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        checkOutput("rst.no_write", 64'(wr_count), 64'(wr_snap));
        checkOutput("rst.no_done", 64'(bus.trap_done), 64'd0);
        rstn = 1'b1;
        trapSteps("rst_restart", 64'h3000, 64'h9, 64'hBEEF, 64'h80001000);
        @(negedge clk);
        checkOutput("rst_restart.idle", 64'(bus.busy), 64'd0);

        checkOutput("ren_we_overlap", 64'(overlap_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
